imem_responder: RTL and testbench

- Memory-side responder for the instruction/data memory request interface: accepts mem_valid requests, models a fixed access latency over an internal word array, and returns a single-cycle mem_ready pulse with mem_rdata.
- Sits between the fetch stage's imem port and the (future) cache/bus. Serves as the synthesizable on-chip instruction RAM and as the bench target for fetch-stage verification.

---
 rtl/imem_responder_if.sv | 39 +++
 rtl/imem_responder.sv | 171 +++++++++++++++++
 tb/tb_imem_responder.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// ---------------------------------------------------------------------------
// imem_responder_if
// Request/response bundle between a memory requester (fetch stage or bench)
// and the imem_responder.
//   mem_valid  request strobe                 (requester -> responder)
//   mem_fence  fence request                  (requester -> responder)
//   mem_spec   speculation/redirect marker    (requester -> responder)
//   mem_instr  instruction access marker      (requester -> responder)
//   mem_addr   byte address                   (requester -> responder)
//   mem_wdata  write data                     (requester -> responder)
//   mem_wstrb  byte write enables, 0 = read   (requester -> responder)
//   mem_ready  single-cycle response strobe   (responder -> requester)
//   mem_rdata  read data, valid with ready    (responder -> requester)
//   busy       request or fence outstanding   (responder -> requester)
// ---------------------------------------------------------------------------
interface imem_responder_if;
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    modport master (
        output mem_valid, mem_fence, mem_spec, mem_instr,
               mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, busy
    );

    modport slave (
        input  mem_valid, mem_fence, mem_spec, mem_instr,
               mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, busy
    );
endinterface

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
// Memory-side responder for the imem request interface. Accepts one request
// at a time, waits a fixed latency, then returns a one-cycle mem_ready with
// the word read from an on-chip array (read-before-write for stores). A
// standalone fence completes after FENCE_LATENCY cycles with rdata = 0.
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    imem_responder_if.slave (request in, ready/rdata/busy out)
//
// Timing: a request presented in cycle c is answered with mem_ready in cycle
// c+LATENCY. The ready cycle is the last BUSY cycle, so a new request in that
// cycle is accepted back-to-back (continuous ready when LATENCY=1).
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int DEPTH         = 4096,
    parameter int LATENCY       = 2,
    parameter int FENCE_LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset,
    imem_responder_if.slave   bus
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXL = (LATENCY > FENCE_LATENCY) ? LATENCY : FENCE_LATENCY;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    localparam logic [CW-1:0] REQ_LOAD   = CW'(LATENCY - 1);
    localparam logic [CW-1:0] FENCE_LOAD = CW'(FENCE_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FENCE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            instr_q, instr_d;
    logic            fence_pend_q, fence_pend_d;
    logic            ready_q, ready_d;
    logic            rsel_q, rsel_d;
    logic [31:0]     rd_word_q;

    logic [31:0]     mem_q [DEPTH];

    logic            complete;
    logic            fence_done;
    logic            can_start;
    logic            accept;
    logic            start_fence;

    // Marker inputs and ignored address bits are intentionally not used.
    logic            unused_ok;
    assign unused_ok = ^{bus.mem_spec, bus.mem_addr[31:AW+2],
                         bus.mem_addr[1:0], instr_q, fence_pend_q};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            instr_q      <= 1'b0;
            fence_pend_q <= 1'b0;
            ready_q      <= 1'b0;
            rsel_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            instr_q      <= instr_d;
            fence_pend_q <= fence_pend_d;
            ready_q      <= ready_d;
            rsel_q       <= rsel_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        complete    = (state_q == ST_BUSY)  && (cnt_q == '0);
        fence_done  = (state_q == ST_FENCE) && (cnt_q == '0);
        // New work is taken when idle or in a request's ready cycle.
        can_start   = (state_q == ST_IDLE) || complete;
        accept      = bus.mem_valid && can_start;
        start_fence = bus.mem_fence && !bus.mem_valid && can_start;

        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        instr_d      = instr_q;
        fence_pend_d = fence_pend_q;

        if (accept) begin
            state_d      = ST_BUSY;
            cnt_d        = REQ_LOAD;
            idx_d        = bus.mem_addr[AW+1:2];
            wdata_d      = bus.mem_wdata;
            wstrb_d      = bus.mem_wstrb;
            instr_d      = bus.mem_instr;
            // A fence riding along with a request is satisfied by its ready.
            fence_pend_d = bus.mem_fence;
        end else if (start_fence) begin
            // Fence issued when nothing else is in flight (idle or in the
            // ready cycle of the previous request): full fence latency.
            state_d      = ST_FENCE;
            cnt_d        = FENCE_LOAD;
            fence_pend_d = 1'b0;
        end else if (complete || fence_done) begin
            // A fence absorbed during the request needs no second pulse.
            state_d      = ST_IDLE;
            cnt_d        = '0;
            fence_pend_d = 1'b0;
        end else if (state_q != ST_IDLE) begin
            cnt_d = cnt_q - 1'b1;
            if (state_q == ST_BUSY && bus.mem_fence) begin
                fence_pend_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: ready is registered one edge ahead of the ready cycle,
    // i.e. whenever the next state is an active state with its count at 0.
    // -----------------------------------------------------------------------
    always_comb begin
        ready_d = (state_d != ST_IDLE) && (cnt_d == '0);
        rsel_d  = (state_d == ST_BUSY) && (cnt_d == '0);
    end

    // Array access at the edge entering the ready cycle; read-first so a
    // store returns the word as it was before the write.
    always_ff @(posedge clock) begin
        if (rsel_d) begin
            rd_word_q <= mem_q[idx_d];
            for (int b = 0; b < 4; b++) begin
                if (wstrb_d[b]) begin
                    mem_q[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_ready = ready_q;
    // Fence responses and idle cycles present zero data.
    assign bus.mem_rdata = rsel_q ? rd_word_q : 32'h0;
    assign bus.busy      = (state_q != ST_IDLE);

    // A new request while a previous one is still counting down is dropped.
    a_no_valid_while_busy : assert property (
        @(posedge clock) disable iff (reset)
        !(bus.mem_valid && state_q == ST_BUSY && cnt_q != '0)
    );

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
// Directed scenarios followed by random legal traffic. A transaction-level
// reference model predicts, for every cycle, whether ready/busy are high and
// what rdata a response carries.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;
    localparam int FLAT  = 4;
    localparam int AW    = 12;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    imem_responder_if bus_if();

    imem_responder #(
        .DEPTH         (DEPTH),
        .LATENCY       (LAT),
        .FENCE_LATENCY (FLAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: memory contents and the single outstanding item.
    logic [31:0] mem_m   [DEPTH];
    bit          known_m [DEPTH];
    bit          out_act;
    bit          out_is_req;
    int          out_issue;
    int          out_done;
    logic [31:0] out_data;
    bit          out_known;

    logic        obs_ready;
    logic        obs_busy;
    logic [31:0] obs_rdata;
    int          ready_seen;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%08h expected=%08h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Compare this cycle's outputs against the model's prediction.
    task automatic check_cycle();
        logic exp_ready;
        logic exp_busy;
        exp_ready = out_act && (cyc == out_done);
        exp_busy  = out_act && (cyc > out_issue);
        obs_ready = bus_if.mem_ready;
        obs_busy  = bus_if.busy;
        obs_rdata = bus_if.mem_rdata;
        check_bit("ready", obs_ready, exp_ready);
        check_bit("busy", obs_busy, exp_busy);
        if (exp_ready && out_known) begin
            check_word("rdata", obs_rdata, out_data);
        end
        if (obs_ready === 1'b1) begin
            ready_seen++;
            $display("resp cyc=%0d kind=%s rdata=%08h", cyc,
                     out_is_req ? "req" : "fence", obs_rdata);
        end
    endtask

    // Advance the model by the inputs presented in this cycle.
    task automatic model_update(input logic v, input logic f, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] ws);
        bit can_acc;
        bit completing;
        int idx;
        can_acc    = !out_act || (out_is_req && cyc == out_done);
        completing = out_act && (cyc == out_done);
        idx        = int'(a[AW+1:2]);
        if (v && can_acc) begin
            out_act    = 1'b1;
            out_is_req = 1'b1;
            out_issue  = cyc;
            out_done   = cyc + LAT;
            out_data   = mem_m[idx];
            out_known  = known_m[idx];
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
            end
            if (ws == 4'hF) known_m[idx] = 1'b1;
        end else if (f && !v && can_acc) begin
            out_act    = 1'b1;
            out_is_req = 1'b0;
            out_issue  = cyc;
            out_done   = cyc + FLAT;
            out_data   = 32'h0;
            out_known  = 1'b1;
        end else if (completing) begin
            out_act = 1'b0;
        end
    endtask

    // One clock cycle: present inputs, check outputs, update model, advance.
    task automatic step(input logic v, input logic f, input logic s, input logic ins,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        bus_if.mem_valid = v;
        bus_if.mem_fence = f;
        bus_if.mem_spec  = s;
        bus_if.mem_instr = ins;
        bus_if.mem_addr  = a;
        bus_if.mem_wdata = wd;
        bus_if.mem_wstrb = ws;
        check_cycle();
        model_update(v, f, a, wd, ws);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Issue one item, then wait until its ready cycle is the current cycle
    // so the next call can issue back-to-back.
    task automatic xact(input logic v, input logic f, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
        step(v, f, 1'b0, 1'b0, a, wd, ws);
        while (out_act && cyc < out_done) idle();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rwd;
        logic [3:0]  rws;
        int          r;
        bit          can_acc;

        out_act    = 1'b0;
        out_is_req = 1'b0;
        out_issue  = 0;
        out_done   = 0;
        out_data   = 32'h0;
        out_known  = 1'b0;
        ready_seen = 0;

        bus_if.mem_valid = 1'b0;
        bus_if.mem_fence = 1'b0;
        bus_if.mem_spec  = 1'b0;
        bus_if.mem_instr = 1'b0;
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'h0;
        bus_if.mem_wstrb = 4'h0;
        reset = 1'b1;

        // Reset state.
        #2;
        check_bit("reset_ready", bus_if.mem_ready, 1'b0);
        check_bit("reset_busy", bus_if.busy, 1'b0);
        check_word("reset_rdata", bus_if.mem_rdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Preload words 0..63 with back-to-back full-word writes.
        for (int i = 0; i < 64; i++) begin
            if (i == 5)      rwd = 32'hDEADBEEF;
            else if (i == 3) rwd = 32'h11223344;
            else             rwd = $urandom;
            xact(1'b1, 1'b0, 32'(i * 4), rwd, 4'hF);
        end
        idle();
        idle();

        // Read latency: ready exactly LAT cycles after the request cycle.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
        idle();
        check_bit("lat_busy_mid", obs_busy, 1'b1);
        idle();
        check_bit("lat_ready", obs_ready, 1'b1);
        check_word("lat_rdata", obs_rdata, 32'hDEADBEEF);
        idle();
        check_bit("lat_ready_drop", obs_ready, 1'b0);
        check_bit("lat_busy_drop", obs_busy, 1'b0);

        // Back-to-back streaming of words 0..3.
        ready_seen = 0;
        for (int i = 0; i < 4; i++) xact(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
        idle();
        idle();
        check_int("stream_readies", ready_seen, 4);

        // Byte write returns old word, then read shows merged word.
        xact(1'b1, 1'b0, 32'hC, 32'hAABBCCDD, 4'b0101);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 32'h0, 4'h0);
        check_word("bytewr_old", obs_rdata, 32'h11223344);
        while (out_act && cyc < out_done) idle();
        idle();
        check_word("bytewr_merged", obs_rdata, 32'h11BB33DD);
        idle();

        // Standalone fence.
        ready_seen = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < FLAT - 1; i++) idle();
        idle();
        check_bit("fence_ready", obs_ready, 1'b1);
        check_word("fence_rdata", obs_rdata, 32'h0);
        for (int i = 0; i < 4; i++) idle();
        check_int("fence_one_ready", ready_seen, 1);

        // Fence during an outstanding read: only the read's ready.
        ready_seen = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h18, 32'h0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) idle();
        check_int("fence_pend_readies", ready_seen, 1);
        check_bit("fence_pend_idle", obs_busy, 1'b0);

        // Request and fence together: absorbed fence, one ready.
        ready_seen = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h1C, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) idle();
        check_int("valid_fence_readies", ready_seen, 1);

        // Speculation marker mid-flight, then a request on the ready cycle.
        ready_seen = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h24, 32'h0, 4'h0);
        check_bit("spec_ready", obs_ready, 1'b1);
        idle();
        idle();
        check_bit("spec_next_ready", obs_ready, 1'b1);
        idle();
        check_int("spec_readies", ready_seen, 2);

        // Asynchronous reset one cycle into a read.
        ready_seen = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 32'h0, 4'h0);
        bus_if.mem_valid = 1'b0;
        check_cycle();
        #3;
        reset = 1'b1;
        #1;
        check_bit("arst_ready", bus_if.mem_ready, 1'b0);
        check_bit("arst_busy", bus_if.busy, 1'b0);
        out_act = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) idle();
        check_int("arst_no_ready", ready_seen, 0);

        // Wraparound: upper address bits ignored.
        xact(1'b1, 1'b0, 32'h4014, 32'h0, 4'h0);
        idle();
        check_word("wrap_rdata", obs_rdata, 32'hDEADBEEF);
        idle();

        // Random legal traffic.
        for (int n = 0; n < 1200; n++) begin
            can_acc = !out_act || (out_is_req && cyc == out_done);
            r   = int'($urandom_range(0, 9));
            ra  = $urandom;
            ra[AW+1:2] = 12'($urandom_range(0, 63));
            rwd = $urandom;
            rws = (r < 3) ? 4'h0 : 4'($urandom_range(0, 15));
            if (can_acc && r < 6) begin
                step(1'b1, (r == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ra, rwd, rws);
            end else if (can_acc && r == 6) begin
                step(1'b0, 1'b1, 1'b0, 1'b0, ra, rwd, rws);
            end else begin
                step(1'b0, (r < 2), 1'($urandom_range(0, 1)), 1'b0, ra, rwd, rws);
            end
        end
        for (int i = 0; i < 8; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
